mem_stage: RTL and testbench

Memory (MEM) stage of the 5-stage RV32I pipeline, between EX and WB. Holds the EX/MEM pipeline registers, computes data-memory byte lane, mask and replicated store data, and detects misaligned accesses. Runs a request/response handshake with data memory, stalling upstream stages while an access is outstanding. Delivers sign/zero-extended load data and retire bookkeeping to the WB stage's combinational inputs.

---
 rtl/mem_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: EX/MEM register, data-memory handshake,
// byte-lane/mask generation, misalignment detection and load extension.
module mem_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_waddr,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid,
  output logic [31:0] o_mem_read_data,
  output logic [31:0] o_mem_read_data_raw,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [1:0]  o_byte_offset,
  output logic        o_unaligned_mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        valid_reg, mem_read_reg, mem_write_reg, reg_write_reg;
  logic [4:0]  rd_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] alu_result_reg, rs2_data_reg, pc_reg, inst_reg;
  logic [1:0]  state_reg, state_next;

  logic [1:0]  byte_off;
  logic        is_half, is_word, misaligned, access, mem_op;
  logic        req, done, load_done;
  logic [3:0]  lane_mask;
  logic [31:0] raw_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_reg      <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      rd_reg         <= 5'd0;
      funct3_reg     <= 3'd0;
      alu_result_reg <= 32'd0;
      rs2_data_reg   <= 32'd0;
      pc_reg         <= 32'd0;
      inst_reg       <= NOP_INST;
    end else if (!o_stall) begin
      valid_reg      <= i_valid;
      mem_read_reg   <= i_mem_read;
      mem_write_reg  <= i_mem_write;
      reg_write_reg  <= i_reg_write;
      rd_reg         <= i_rd;
      funct3_reg     <= i_funct3;
      alu_result_reg <= i_alu_result;
      rs2_data_reg   <= i_rs2_data;
      pc_reg         <= i_pc;
      inst_reg       <= i_inst;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  assign byte_off   = alu_result_reg[1:0];
  assign is_half    = (funct3_reg[1:0] == 2'b01);
  assign is_word    = (funct3_reg[1:0] == 2'b10);
  assign misaligned = (is_half & byte_off[0]) | (is_word & (byte_off != 2'b00));
  assign access     = valid_reg & (mem_read_reg | mem_write_reg);
  assign mem_op     = access & ~misaligned;

  // A load is never finished at acceptance; it always waits in RESP for rvalid.
  always_comb begin
    state_next = state_reg;
    req        = 1'b0;
    done       = 1'b0;
    load_done  = 1'b0;
    case (state_reg)
      S_IDLE, S_REQ: begin
        if (mem_op) begin
          req = 1'b1;
          if (i_dmem_ready) begin
            if (mem_read_reg) state_next = S_RESP;
            else begin
              done       = 1'b1;
              state_next = S_IDLE;
            end
          end else begin
            state_next = S_REQ;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RESP: begin
        if (i_dmem_rvalid) begin
          done       = 1'b1;
          load_done  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (funct3_reg[1:0])
      2'b00:   lane_mask = 4'b0001 << byte_off;
      2'b01:   lane_mask = 4'b0011 << byte_off;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Each lane carries the low byte (B), the matching half byte (H) or its own byte (W).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_comb begin
      case (funct3_reg[1:0])
        2'b00:   o_dmem_wdata[8*gi +: 8] = rs2_data_reg[7:0];
        2'b01:   o_dmem_wdata[8*gi +: 8] = rs2_data_reg[8*(gi%2) +: 8];
        default: o_dmem_wdata[8*gi +: 8] = rs2_data_reg[8*gi +: 8];
      endcase
    end
  end

  assign raw_data = load_done ? i_dmem_rdata : 32'd0;
  assign byte_sel = raw_data[{byte_off, 3'b000} +: 8];
  assign half_sel = raw_data[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_reg)
      3'b000:  o_mem_read_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  o_mem_read_data = {24'd0, byte_sel};
      3'b001:  o_mem_read_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  o_mem_read_data = {16'd0, half_sel};
      default: o_mem_read_data = raw_data;
    endcase
  end

  assign o_stall             = mem_op & ~done;
  assign o_dmem_req          = req;
  assign o_dmem_we           = req & mem_write_reg;
  assign o_dmem_waddr        = {alu_result_reg[31:2], 2'b00};
  assign o_dmem_mask         = req ? lane_mask : 4'b0000;
  assign o_valid             = valid_reg & ~o_stall;
  assign o_mem_read_data_raw = raw_data;
  assign o_alu_result        = alu_result_reg;
  assign o_dmem_addr         = alu_result_reg;
  assign o_pc                = pc_reg;
  assign o_inst              = inst_reg;
  assign o_rd                = rd_reg;
  assign o_reg_write         = reg_write_reg;
  assign o_mem_read          = mem_read_reg;
  assign o_mem_write         = mem_write_reg;
  assign o_byte_offset       = byte_off;
  assign o_unaligned_mem     = access & misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: one EX instruction per
// transaction, dmem handshake driven cycle by cycle.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] alu_result = 32'd0, rs2_data = 32'd0, pc = 32'd0, inst = 32'd0;
  logic        dmem_ready = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  logic        stall, dmem_req, dmem_we, out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic        unaligned_mem;
  logic [3:0]  dmem_mask;
  logic [1:0]  byte_offset;
  logic [4:0]  out_rd;
  logic [31:0] dmem_waddr, dmem_wdata, read_data, read_data_raw;
  logic [31:0] out_alu_result, dmem_addr, out_pc, out_inst;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk(clk), .i_rst(rst),
    .i_valid(valid), .i_mem_read(mem_read), .i_mem_write(mem_write), .i_reg_write(reg_write),
    .i_rd(rd), .i_funct3(funct3), .i_alu_result(alu_result), .i_rs2_data(rs2_data),
    .i_pc(pc), .i_inst(inst),
    .o_stall(stall), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_waddr(dmem_waddr),
    .o_dmem_mask(dmem_mask), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ready(dmem_ready), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_valid(out_valid), .o_mem_read_data(read_data), .o_mem_read_data_raw(read_data_raw),
    .o_alu_result(out_alu_result), .o_dmem_addr(dmem_addr), .o_pc(out_pc), .o_inst(out_inst),
    .o_rd(out_rd), .o_reg_write(out_reg_write), .o_mem_read(out_mem_read),
    .o_mem_write(out_mem_write), .o_byte_offset(byte_offset), .o_unaligned_mem(unaligned_mem)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic r, input logic w, input logic rw,
                          input logic [4:0] d, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] s, input logic [31:0] p, input logic [31:0] i);
    valid = v; mem_read = r; mem_write = w; reg_write = rw; rd = d;
    funct3 = f3; alu_result = a; rs2_data = s; pc = p; inst = i;
  endtask

  task automatic bubble();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'h13);
  endtask

  // Step past the next rising edge; inputs set after this apply to the new cycle.
  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    sample();
    check_value("rst_stall", {31'd0, stall}, 32'd0);
    check_value("rst_req", {31'd0, dmem_req}, 32'd0);
    check_value("rst_mask", {28'd0, dmem_mask}, 32'd0);
    check_value("rst_valid", {31'd0, out_valid}, 32'd0);
    check_value("rst_inst", out_inst, 32'h13);
    check_value("rst_raw", read_data_raw, 32'd0);
    #1 rst = 1'b0;
    $display("txn reset done");

    // ADDI x1, result 0x55
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 3'b000, 32'h55, 32'd0, 32'h100, 32'h05500093);
    advance(); bubble();
    sample();
    check_value("addi_valid", {31'd0, out_valid}, 32'd1);
    check_value("addi_alu", out_alu_result, 32'h55);
    check_value("addi_stall", {31'd0, stall}, 32'd0);
    check_value("addi_req", {31'd0, dmem_req}, 32'd0);
    check_value("addi_rd", {27'd0, out_rd}, 32'd1);
    $display("txn addi done");

    // SB 0xAB -> 0x1003, ready immediately
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'b000, 32'h1003, 32'h000000AB, 32'h104, 32'h00208023);
    advance(); bubble(); dmem_ready = 1'b1;
    sample();
    check_value("sb_req", {31'd0, dmem_req}, 32'd1);
    check_value("sb_we", {31'd0, dmem_we}, 32'd1);
    check_value("sb_mask", {28'd0, dmem_mask}, 32'h8);
    check_value("sb_wdata", dmem_wdata, 32'hABABABAB);
    check_value("sb_waddr", dmem_waddr, 32'h1000);
    check_value("sb_stall", {31'd0, stall}, 32'd0);
    check_value("sb_valid", {31'd0, out_valid}, 32'd1);
    $display("txn sb done");

    // LB 0x2001, accepted at once, rvalid next cycle
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 3'b000, 32'h2001, 32'd0, 32'h108, 32'h00100183);
    advance(); bubble(); dmem_ready = 1'b1;
    sample();
    check_value("lb_stall1", {31'd0, stall}, 32'd1);
    check_value("lb_req", {31'd0, dmem_req}, 32'd1);
    check_value("lb_mask", {28'd0, dmem_mask}, 32'h2);
    check_value("lb_valid1", {31'd0, out_valid}, 32'd0);
    advance(); dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h000080FF;
    sample();
    check_value("lb_stall2", {31'd0, stall}, 32'd0);
    check_value("lb_req2", {31'd0, dmem_req}, 32'd0);
    check_value("lb_valid2", {31'd0, out_valid}, 32'd1);
    check_value("lb_data", read_data, 32'hFFFFFF80);
    check_value("lb_raw", read_data_raw, 32'h000080FF);
    advance(); dmem_rvalid = 1'b0;
    $display("txn lb done");

    // LHU 0x2002: ready low 2 cycles, rvalid 3 cycles after acceptance
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 3'b101, 32'h2002, 32'd0, 32'h10C, 32'h00205203);
    advance(); bubble();
    stall_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      dmem_ready  = (k == 2);
      dmem_rvalid = (k == 1) || (k == 5);  // rvalid while still in REQ must be ignored
      dmem_rdata  = (k == 5) ? 32'hBEEF1234 : 32'h5A5A5A5A;
      sample();
      if (stall) stall_cnt++;
      if (k <= 2) begin
        check_value($sformatf("lhu_req_c%0d", k), {31'd0, dmem_req}, 32'd1);
        check_value($sformatf("lhu_waddr_c%0d", k), dmem_waddr, 32'h2000);
        check_value($sformatf("lhu_mask_c%0d", k), {28'd0, dmem_mask}, 32'hC);
      end
      if (k == 1) check_value("lhu_early_rvalid_stall", {31'd0, stall}, 32'd1);
      if (k == 3) check_value("lhu_raw_idle", read_data_raw, 32'd0);
      if (k == 5) begin
        check_value("lhu_data", read_data, 32'h0000BEEF);
        check_value("lhu_valid", {31'd0, out_valid}, 32'd1);
      end
      advance();
    end
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    check_value("lhu_stall_cycles", stall_cnt, 32'd5);
    $display("txn lhu done (%0d stall cycles)", stall_cnt);

    // LW 0x2006: misaligned
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 3'b010, 32'h2006, 32'd0, 32'h110, 32'h00602283);
    advance(); bubble(); dmem_ready = 1'b1;
    sample();
    check_value("lw_mis_req", {31'd0, dmem_req}, 32'd0);
    check_value("lw_mis_flag", {31'd0, unaligned_mem}, 32'd1);
    check_value("lw_mis_valid", {31'd0, out_valid}, 32'd1);
    check_value("lw_mis_mask", {28'd0, dmem_mask}, 32'd0);
    check_value("lw_mis_stall", {31'd0, stall}, 32'd0);
    $display("txn lw_misaligned done");

    // SH 0x1002 with one cycle of ready low, then LB 0x2003 back-to-back
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 3'b001, 32'h1002, 32'h1234ABCD, 32'h114, 32'h00209123);
    advance(); bubble(); dmem_ready = 1'b0;
    sample();
    check_value("sh_stall1", {31'd0, stall}, 32'd1);
    check_value("sh_mask", {28'd0, dmem_mask}, 32'hC);
    check_value("sh_wdata", dmem_wdata, 32'hABCDABCD);
    advance(); dmem_ready = 1'b1;
    sample();
    check_value("sh_stall2", {31'd0, stall}, 32'd0);
    check_value("sh_valid", {31'd0, out_valid}, 32'd1);
    $display("txn sh done");
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 3'b000, 32'h2003, 32'd0, 32'h118, 32'h00300303);
    advance(); bubble(); dmem_ready = 1'b1;
    sample();
    check_value("b2b_req", {31'd0, dmem_req}, 32'd1);
    check_value("b2b_mask", {28'd0, dmem_mask}, 32'h8);
    advance(); dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h7F000000;
    sample();
    check_value("b2b_data", read_data, 32'h0000007F);
    advance(); dmem_rvalid = 1'b0;
    $display("txn lb_back_to_back done");

    // LW 0x3000 interrupted by async reset while waiting in RESP
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 3'b010, 32'h3000, 32'd0, 32'h11C, 32'h00002383);
    advance(); bubble(); dmem_ready = 1'b1;
    sample();
    check_value("rstmid_stall1", {31'd0, stall}, 32'd1);
    advance(); dmem_ready = 1'b0;
    sample();
    check_value("rstmid_stall2", {31'd0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_value("rstmid_stall", {31'd0, stall}, 32'd0);
    check_value("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check_value("rstmid_req", {31'd0, dmem_req}, 32'd0);
    sample();
    #1 rst = 1'b0;
    advance(); dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    sample();
    check_value("late_rvalid_valid", {31'd0, out_valid}, 32'd0);
    check_value("late_rvalid_raw", read_data_raw, 32'd0);
    check_value("late_rvalid_stall", {31'd0, stall}, 32'd0);
    advance(); dmem_rvalid = 1'b0;
    $display("txn reset_in_resp done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
